// File: rtl/leitor_aprovados_pkg.sv
// Shared defaults and FSM encoding for the approved-slot reader and its evaluator.
package leitor_aprovados_pkg;

  localparam int unsigned NumAtivosPadrao = 24;
  localparam int unsigned NodeWidthPadrao = 8;
  localparam int unsigned IdxWidthPadrao  = 5;
  localparam int unsigned ContWidthPadrao = 5;

  typedef enum logic [1:0] {
    StOcioso = 2'd0,
    StEnvia  = 2'd1,
    StFim    = 2'd2
  } estado_t;

endpackage

// File: rtl/leitor_aprovados_if.sv
// Capture/offer handshake bundle between the evaluator, the reader and the consumer.
interface leitor_aprovados_if
  import leitor_aprovados_pkg::*;
#(
  parameter int unsigned NUM_ATIVOS = NumAtivosPadrao,
  parameter int unsigned NODE_WIDTH = NodeWidthPadrao,
  parameter int unsigned IDX_WIDTH  = IdxWidthPadrao,
  parameter int unsigned CONT_WIDTH = ContWidthPadrao
);
  logic                             iniciar_in;
  logic [NUM_ATIVOS-1:0]            aprovados_in;
  logic [NUM_ATIVOS*NODE_WIDTH-1:0] ativos_in;
  logic                             pronto_in;
  logic [NODE_WIDTH-1:0]            no_out;
  logic [IDX_WIDTH-1:0]             slot_out;
  logic                             valido_out;
  logic                             ocupado_out;
  logic                             fim_out;
  logic [CONT_WIDTH-1:0]            total_out;

  // Reader side.
  modport slave (
    input  iniciar_in, aprovados_in, ativos_in, pronto_in,
    output no_out, slot_out, valido_out, ocupado_out, fim_out, total_out
  );

  // Producer/consumer side.
  modport master (
    output iniciar_in, aprovados_in, ativos_in, pronto_in,
    input  no_out, slot_out, valido_out, ocupado_out, fim_out, total_out
  );
endinterface

// File: rtl/codificador_prioridade.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module codificador_prioridade #(
  parameter int unsigned NUM_ATIVOS = 24,
  parameter int unsigned IDX_WIDTH  = 5
) (
  input  logic [NUM_ATIVOS-1:0] vetor,
  output logic [IDX_WIDTH-1:0]  indice,
  output logic                  algum
);
  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    indice = '0;
    algum  = 1'b0;
    for (int i = NUM_ATIVOS - 1; i >= 0; i--) begin
      if (vetor[i]) begin
        indice = IDX_WIDTH'(i);
        algum  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/leitor_aprovados.sv
// Captures an approval bitmap plus slot table and drains approved slots in ascending order.
module leitor_aprovados
  import leitor_aprovados_pkg::*;
#(
  parameter int unsigned NUM_ATIVOS = NumAtivosPadrao,
  parameter int unsigned NODE_WIDTH = NodeWidthPadrao,
  parameter int unsigned IDX_WIDTH  = IdxWidthPadrao,
  parameter int unsigned CONT_WIDTH = ContWidthPadrao
) (
  input logic               clk_in,
  input logic               rst_n_in,
  leitor_aprovados_if.slave bus
);
  estado_t                          estado_q, estado_d;
  logic [NUM_ATIVOS-1:0]            mask_q, mask_d;
  logic [NUM_ATIVOS*NODE_WIDTH-1:0] snap_q, snap_d;
  logic [CONT_WIDTH-1:0]            total_q, total_d;
  logic [IDX_WIDTH-1:0]             prox_idx;
  logic                             algum;
  logic                             valido;

  codificador_prioridade #(
    .NUM_ATIVOS(NUM_ATIVOS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_codificador (
    .vetor (mask_q),
    .indice(prox_idx),
    .algum (algum)
  );

  // Offer depends only on registered state, never on pronto_in.
  assign valido = (estado_q == StEnvia) && algum;

  always_comb begin
    estado_d = estado_q;
    mask_d   = mask_q;
    snap_d   = snap_q;
    total_d  = total_q;
    unique case (estado_q)
      StOcioso: begin
        if (bus.iniciar_in) begin
          mask_d   = bus.aprovados_in;
          snap_d   = bus.ativos_in;
          total_d  = '0;
          estado_d = StEnvia;
        end
      end
      StEnvia: begin
        if (!algum) begin
          estado_d = StFim;
        end else if (bus.pronto_in) begin
          mask_d  = mask_q & (mask_q - 1'b1);
          total_d = total_q + 1'b1;
        end
      end
      StFim:   estado_d = StOcioso;
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      estado_q <= StOcioso;
      mask_q   <= '0;
      snap_q   <= '0;
      total_q  <= '0;
    end else begin
      estado_q <= estado_d;
      mask_q   <= mask_d;
      snap_q   <= snap_d;
      total_q  <= total_d;
    end
  end

  assign bus.valido_out  = valido;
  assign bus.slot_out    = valido ? prox_idx : '0;
  assign bus.no_out      = valido ? snap_q[prox_idx*NODE_WIDTH +: NODE_WIDTH] : '0;
  assign bus.ocupado_out = (estado_q != StOcioso);
  assign bus.fim_out     = (estado_q == StFim);
  assign bus.total_out   = total_q;
endmodule
